// File: rtl/bip_result_tx_pkg.sv
// rtl/bip_result_tx_pkg.sv - shared BIP result transmitter types and constants
package bip_result_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BYTES = 3;
  localparam int BYTE_BITS   = 8;

  localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);
  localparam logic [2:0] LAST_BIT  = 3'(BYTE_BITS - 1);

  // Frame order: accumulator high byte, accumulator low byte, cycle count.
  function automatic logic [7:0] frame_byte(input logic [15:0] acc,
                                            input logic [7:0]  cnt,
                                            input logic [1:0]  idx);
    case (idx)
      2'd0:    frame_byte = acc[15:8];
      2'd1:    frame_byte = acc[7:0];
      default: frame_byte = cnt;
    endcase
  endfunction

endpackage

// File: rtl/bip_result_tx_if.sv
// rtl/bip_result_tx_if.sv - BIP result bus and UART status bundle
interface bip_result_tx_if;
  import bip_result_tx_pkg::*;

  logic        done;
  logic [15:0] acumulador;
  logic [7:0]  clk_count;
  logic        tx;
  logic        busy;
  logic        sent;

  modport master (
    output done, acumulador, clk_count,
    input  tx, busy, sent
  );

  modport slave (
    input  done, acumulador, clk_count,
    output tx, busy, sent
  );

endinterface

// File: rtl/bip_result_tx_baud_gen.sv
// rtl/bip_result_tx_baud_gen.sv - bit-period counter with synchronous clear
module bip_baud_gen #(
  parameter int BAUD_DIV = 10416
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Tick marks the final cycle of a bit period; a cleared counter never ticks.
  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/bip_result_tx.sv
// rtl/bip_result_tx.sv - sends BIP accumulator and cycle count as a 3-byte 8N1 UART frame
module bip_result_tx
  import bip_result_tx_pkg::*;
#(
  parameter int BAUD_DIV = 10416
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done,
  input  logic [15:0] acumulador,
  input  logic [7:0]  clk_count,
  output logic        tx,
  output logic        busy,
  output logic        sent
);

  tx_state_t   state;
  logic        done_d;
  logic [15:0] lat_acc;
  logic [7:0]  lat_cnt;
  logic [1:0]  byte_idx;
  logic [2:0]  bit_idx;
  logic        tick;
  logic        trigger;
  logic [7:0]  cur_byte;
  logic [2:0]  nxt_bit;

  assign trigger  = done && !done_d;
  assign cur_byte = frame_byte(lat_acc, lat_cnt, byte_idx);
  assign nxt_bit  = bit_idx + 3'd1;

  // Holding the timer cleared in IDLE restarts the bit period on the trigger edge.
  bip_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .rst_n (reset),
    .clear (state == ST_IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      done_d   <= 1'b0;
      lat_acc  <= '0;
      lat_cnt  <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      sent     <= 1'b0;
    end else begin
      done_d <= done;
      sent   <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (trigger) begin
            lat_acc  <= acumulador;
            lat_cnt  <= clk_count;
            byte_idx <= '0;
            bit_idx  <= '0;
            state    <= ST_START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= cur_byte[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              state   <= ST_STOP;
              bit_idx <= '0;
              tx      <= 1'b1;
            end else begin
              bit_idx <= nxt_bit;
              tx      <= cur_byte[nxt_bit];
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (byte_idx == LAST_BYTE) begin
              state    <= ST_IDLE;
              byte_idx <= '0;
              busy     <= 1'b0;
              sent     <= 1'b1;
              tx       <= 1'b1;
            end else begin
              state    <= ST_START;
              byte_idx <= byte_idx + 2'd1;
              tx       <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bip_result_tx.md
BIP_RESULT_TX -- requirements
Module: bip_result_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 10416, clock cycles per UART bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port done  input  1  BIP halted indication, level; a new result is signalled by a 0->1 transition.
REQ-005 SHALL have port acumulador  input  16  BIP accumulator value.
REQ-006 SHALL have port clk_count  input  8  BIP executed-cycle count.
REQ-007 SHALL have port tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is being sent.
REQ-009 SHALL have port sent  output  1  one-cycle pulse when the full 3-byte frame has finished.

Function
REQ-010 SHALL register done each cycle (done_d) and detect a trigger when done=1 and done_d=0.
REQ-011 SHALL, on a trigger edge in IDLE, latch acumulador and clk_count into internal registers and enter START on that same edge.
REQ-012 SHALL ignore triggers while busy=1; no queuing, latched data unaffected.
REQ-013 SHALL not retrigger while done stays high; a new frame requires done to return low for at least one cycle.
REQ-014 SHALL transmit a frame of 3 bytes in order: acumulador[15:8], acumulador[7:0], clk_count.
REQ-015 SHALL encode each byte as start bit 0, data bits 0..7 LSB first, stop bit 1; no parity, no inter-byte gap.
REQ-016 SHALL hold every bit on tx for exactly BAUD_DIV cycles, with the bit timer restarted at the trigger edge.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP: IDLE->START on trigger; START->DATA after BAUD_DIV; DATA->DATA for bits 0..6; DATA->STOP after bit 7; STOP->START if byte index < 2; STOP->IDLE after byte index 2.
REQ-018 SHALL use a 3-bit bit index (0..7) and a 2-bit byte index (0..2); neither exceeds its range.
REQ-019 SHALL drive tx high in IDLE and STOP, low in START, and the selected data bit in DATA; tx is registered.
REQ-020 SHALL assert busy=1 from the trigger edge through the last stop bit, i.e. exactly 30*BAUD_DIV cycles.
REQ-021 SHALL pulse sent=1 for one cycle on the edge where STOP->IDLE occurs; busy falls on the same edge.
REQ-022 SHALL accept a new trigger on the first cycle in IDLE after sent.

Reset
REQ-023 SHALL, while reset=0, force FSM=IDLE, tx=1, busy=0, sent=0, done_d=0, all counters and latched data=0, independent of clk.
REQ-024 SHALL abort any frame in progress on reset assertion; no partial-byte completion.
REQ-025 SHALL, after reset release with done already high, treat it as a trigger on the first clock edge (done_d=0).

Structure
REQ-026 SHALL place FSM state encoding, frame byte count (3) and bit count (8) in the shared BIP package.
REQ-027 SHALL instantiate one sub-module bip_baud_gen: BAUD_DIV counter with synchronous clear input, one-cycle tick output at bit end.
REQ-028 SHALL be sized at 120-400 lines RTL total, including bip_baud_gen.

Verification
REQ-029 SHALL verify BAUD_DIV=4, acumulador=0x1234, clk_count=0x2A, done 0->1 -> tx: start(4 cyc), bits 0,1,0,0,1,0,0,0, stop; then 0x34, then 0x2A; busy high 120 cycles; sent one pulse at cycle 120.
REQ-030 SHALL verify second done rise at cycle 50 of a frame (done low for 10 cycles, then high) -> frame unchanged, no second frame, single sent pulse.
REQ-031 SHALL verify acumulador changed to 0xFFFF mid-frame -> transmitted bytes still 0x12,0x34,0x2A.
REQ-032 SHALL verify reset asserted at cycle 60 of a frame -> tx=1, busy=0, sent=0 immediately (asynchronous), no further tx activity until a new trigger.
REQ-033 SHALL verify done held high 500 cycles -> exactly one frame; done low 1 cycle then high after sent -> second frame starts on that edge.
REQ-034 SHALL verify acumulador=0x0000, clk_count=0xFF -> bytes 0x00,0x00,0xFF with correct framing and stop bits high.
